vedic_seq_mul: RTL and testbench
================================

VEDIC_SEQ_MUL -- requirements
Module: vedic_seq_mul

Interface
REQ-001 The block SHALL have parameter DIGITS, default 4: the number of 3-bit digits per operand; operand width W = 3*DIGITS.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the operands are presented.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept operands.
REQ-006 The block SHALL have port a, input, W bits: the unsigned multiplicand.
REQ-007 The block SHALL have port b, input, W bits: the unsigned multiplier.
REQ-008 The block SHALL have port out_valid, output, 1 bit: the product is available.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the product.
REQ-010 The block SHALL have port p, output, 2W bits: the unsigned product.
REQ-011 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-012 The block SHALL compute p = a*b by time-sharing one 3x3 vedic multiplier core over the DIGITS^2 digit pairs.
REQ-013 The FSM SHALL have exactly the three states IDLE, CALC and DONE.
REQ-014 In IDLE, in_ready SHALL be 1; in CALC and DONE, in_ready SHALL be 0.
REQ-015 Accept: on a rising edge with in_valid=1 and in_ready=1, the block SHALL latch a and b, clear the accumulator, set the digit indices i=j=0, and go to CALC.
REQ-016 In each CALC cycle, the block SHALL add the core product of a-digit i and b-digit j, shifted left by 3*(i+j), to the 2W-bit accumulator.
REQ-017 Index order in CALC SHALL be: increment j; when j=DIGITS-1, reset j to 0 and increment i (i outer, j inner).
REQ-018 On the edge that accumulates pair (DIGITS-1, DIGITS-1), the FSM SHALL go to DONE.
REQ-019 CALC SHALL last exactly DIGITS^2 cycles, with no early termination for zero operands.
REQ-020 out_valid SHALL rise on the DIGITS^2-th rising edge after the accepting edge (16 for the default).
REQ-021 The accumulator SHALL be exactly 2W bits and SHALL never overflow; no saturation or truncation SHALL be applied.
REQ-022 In DONE, out_valid SHALL be 1, and p SHALL equal the accumulator and hold stable while out_ready=0.
REQ-023 In DONE with out_ready=1, the FSM SHALL return to IDLE on that edge.
REQ-024 A new accept SHALL be possible no earlier than the following cycle, so the back-to-back period is DIGITS^2+2 cycles.
REQ-025 in_valid SHALL be ignored in CALC and DONE, and the latched operands SHALL be unaffected by changes on a or b after the accept.
REQ-026 In IDLE, out_valid SHALL be 0 and p SHALL hold the last product (0 after reset).

Reset
REQ-027 On rst_n=0, asynchronously: state=IDLE, accumulator=0, p=0, i=j=0, out_valid=0, busy=0, in_ready=1 (combinational from IDLE).
REQ-028 Reset asserted mid-CALC or in DONE SHALL abort the operation with no output, and the block SHALL resume in IDLE after rst_n deasserts.

Structure
REQ-029 The shared package vedic_pkg SHALL hold the digit width constant DIG_W=3 and the FSM state encoding (IDLE, CALC, DONE).
REQ-030 The block SHALL contain exactly one instance of the existing vedic_3 sub-module, with inputs muxed from the latched operands by i and j.
REQ-031 Digit select, shift and accumulate SHALL be local logic, with no further sub-modules.

Verification
REQ-032 The bench SHALL cover: reset, then a=0xABC, b=0x123 accepted -> out_valid after 16 edges with p=0x0C33B4.
REQ-033 The bench SHALL cover: a=0xFFF, b=0xFFF -> p=0xFFE001, and CALC lasts 16 cycles.
REQ-034 The bench SHALL cover: a=0, b=0x5A5 -> p=0 after the full 16-cycle latency.
REQ-035 The bench SHALL cover: out_ready held 0 for 5 cycles in DONE -> out_valid and p stable, in_ready=0; in_valid pulsed during CALC/DONE -> not accepted.
REQ-036 The bench SHALL cover: rst_n pulsed low at CALC cycle 7 -> out_valid=0, busy=0, p=0 immediately; the next operation 0x007*0x007 -> p=0x000031.
REQ-037 The bench SHALL cover: back-to-back random operands with out_ready=1 -> every p equals the reference a*b and the accept spacing is 18 cycles.

Source files
------------

// File: rtl/vedic_pkg.sv
// Shared constants and FSM encoding for the sequential vedic multiplier.
package vedic_pkg;

    localparam int unsigned DIG_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/vedic_3.sv
// 3x3 unsigned multiplier using the urdhva-tiryakbhyam (vertical and crosswise) column sums.
module vedic_3 (
    input  logic [2:0] i_a,
    input  logic [2:0] i_b,
    output logic [5:0] o_p
);

    logic       w_c0;
    logic [1:0] w_c1;
    logic [1:0] w_c2;
    logic [1:0] w_c3;
    logic       w_c4;

    // Column sums of the crosswise partial products, then weighted recombination.
    always_comb begin
        w_c0 = i_a[0] & i_b[0];
        w_c1 = {1'b0, i_a[1] & i_b[0]} + {1'b0, i_a[0] & i_b[1]};
        w_c2 = {1'b0, i_a[2] & i_b[0]} + {1'b0, i_a[1] & i_b[1]} + {1'b0, i_a[0] & i_b[2]};
        w_c3 = {1'b0, i_a[2] & i_b[1]} + {1'b0, i_a[1] & i_b[2]};
        w_c4 = i_a[2] & i_b[2];
        o_p  = {5'b0, w_c0}
             + {3'b0, w_c1, 1'b0}
             + {2'b0, w_c2, 2'b0}
             + {1'b0, w_c3, 3'b0}
             + {1'b0, w_c4, 4'b0};
    end

endmodule

// File: rtl/vedic_seq_mul.sv
// Sequential W x W multiplier time-sharing one 3x3 vedic core over all digit pairs.
module vedic_seq_mul
    import vedic_pkg::*;
#(
    parameter int unsigned DIGITS = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DIG_W*DIGITS-1:0]       a,
    input  logic [DIG_W*DIGITS-1:0]       b,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [2*DIG_W*DIGITS-1:0]     p,
    output logic                          busy
);

    localparam int unsigned W      = DIG_W * DIGITS;
    localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned IDX_W1 = IDX_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    state_t               r_state;
    state_t               w_next;
    logic [W-1:0]         r_a;
    logic [W-1:0]         r_b;
    logic [IDX_W-1:0]     r_i;
    logic [IDX_W-1:0]     r_j;
    logic [2*W-1:0]       r_acc;
    logic [2*W-1:0]       r_p;
    logic [DIG_W-1:0]     w_a_dig;
    logic [DIG_W-1:0]     w_b_dig;
    logic [2*DIG_W-1:0]   w_core;
    logic [IDX_W:0]       w_dsum;
    logic [2*W-1:0]       w_ext;
    logic [2*W-1:0]       w_term;
    logic [2*W-1:0]       w_sum;
    logic                 w_accept;
    logic                 w_last;

    vedic_3 u_core (
        .i_a (w_a_dig),
        .i_b (w_b_dig),
        .o_p (w_core)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        w_accept  = 1'b0;
        w_last    = (r_i == LAST_IDX) && (r_j == LAST_IDX);
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                w_accept = in_valid;
                if (in_valid) w_next = CALC;
            end
            CALC: begin
                if (w_last) w_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Digit select from latched operands, then shift the core product into place.
    always_comb begin
        w_a_dig = '0;
        w_b_dig = '0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (r_i == IDX_W'(k)) w_a_dig = r_a[k*DIG_W +: DIG_W];
            if (r_j == IDX_W'(k)) w_b_dig = r_b[k*DIG_W +: DIG_W];
        end
        w_dsum = {1'b0, r_i} + {1'b0, r_j};
        w_ext  = '0;
        w_ext[2*DIG_W-1:0] = w_core;
        w_term = '0;
        for (int unsigned k = 0; k < 2*DIGITS-1; k++) begin
            if (w_dsum == IDX_W1'(k)) w_term = w_ext << (k*DIG_W);
        end
        w_sum = r_acc + w_term;
    end

    // Operand latch, digit indices, accumulator and held product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_i   <= '0;
            r_j   <= '0;
            r_acc <= '0;
            r_p   <= '0;
        end else if (w_accept) begin
            r_a   <= a;
            r_b   <= b;
            r_i   <= '0;
            r_j   <= '0;
            r_acc <= '0;
        end else if (r_state == CALC) begin
            r_acc <= w_sum;
            if (w_last) begin
                r_i <= '0;
                r_j <= '0;
                r_p <= w_sum;
            end else if (r_j == LAST_IDX) begin
                r_j <= '0;
                r_i <= r_i + 1'b1;
            end else begin
                r_j <= r_j + 1'b1;
            end
        end
    end

    assign p = r_p;

endmodule

// File: tb/tb_vedic_seq_mul.sv
// Scoreboard bench for vedic_seq_mul: driver pushes a*b, negedge monitor pops and compares.
module tb_vedic_seq_mul;

    localparam int DIGITS = 4;
    localparam int W      = 3 * DIGITS;
    localparam int LAT    = DIGITS * DIGITS;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] p;
    logic           busy;

    int             n_cmp = 0;
    int             n_err = 0;
    int             cyc   = 0;
    int             last_acc = -1;
    logic           prev_valid = 1'b0;
    logic [2*W-1:0] exp_q[$];
    int             acc_q[$];
    logic [2*W-1:0] held;

    vedic_seq_mul #(.DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
        end
    endtask

    task automatic fail_now(input string nm);
        n_cmp++;
        n_err++;
        $display("FAIL %s: bound expired or unexpected event", nm);
    endtask

    // Monitor: latency at out_valid rise, product at each handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && !prev_valid) begin
                if (acc_q.size() == 0) fail_now("spurious_out_valid");
                else chk("latency", 48'(cyc - acc_q[0]), 48'(LAT));
                chk("in_ready_in_done", 48'(in_ready), 48'(0));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_product");
                end else begin
                    chk("product", 48'(p), 48'(exp_q.pop_front()));
                    void'(acc_q.pop_front());
                end
            end
        end
        prev_valid = out_valid;
    end

    // Present operands once in_ready is seen; spacing checked when b2b is set.
    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input bit b2b);
        int t = 0;
        while (!in_ready && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (!in_ready) begin
            fail_now("accept_timeout");
            return;
        end
        in_valid = 1'b1;
        a = ia;
        b = ib;
        exp_q.push_back(24'(ia) * 24'(ib));
        acc_q.push_back(cyc + 1);
        if (b2b && last_acc >= 0) chk("accept_spacing", 48'(cyc + 1 - last_acc), 48'(LAT + 2));
        last_acc = cyc + 1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (exp_q.size() != 0) fail_now("drain_timeout");
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 48'(in_ready), 48'(1));
        chk("rst_out_valid", 48'(out_valid), 48'(0));
        chk("rst_busy", 48'(busy), 48'(0));
        chk("rst_p", 48'(p), 48'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed products with known constants.
        issue(12'hABC, 12'h123, 1'b0);
        drain();
        chk("abc_x_123", 48'(p), 48'h0C33B4);
        issue(12'hFFF, 12'hFFF, 1'b0);
        drain();
        chk("fff_x_fff", 48'(p), 48'hFFE001);
        issue(12'h000, 12'h5A5, 1'b0);
        drain();
        chk("zero_x_5a5", 48'(p), 48'h0);

        // Back-pressure in DONE, in_valid pulses in CALC and DONE.
        out_ready = 1'b0;
        issue(W'($urandom), W'($urandom), 1'b0);
        repeat (3) begin
            in_valid = 1'b1;
            a = W'($urandom);
            b = W'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        begin
            int t = 0;
            while (!out_valid && t < 40) begin
                @(negedge clk);
                t++;
            end
            if (!out_valid) fail_now("done_timeout");
        end
        held = p;
        chk("hold_p_is_product", 48'(held), 48'(exp_q[0]));
        repeat (5) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            a = W'($urandom);
            b = W'($urandom);
            @(negedge clk);
            chk("hold_out_valid", 48'(out_valid), 48'(1));
            chk("hold_p", 48'(p), 48'(held));
            chk("hold_in_ready", 48'(in_ready), 48'(0));
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();
        repeat (3) @(posedge clk);
        #1;
        chk("no_accept_after_hold", 48'(busy), 48'(0));

        // Reset during CALC aborts the operation.
        issue(W'($urandom_range(1, 4095)), W'($urandom_range(1, 4095)), 1'b0);
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 48'(out_valid), 48'(0));
        chk("abort_busy", 48'(busy), 48'(0));
        chk("abort_p", 48'(p), 48'(0));
        chk("abort_in_ready", 48'(in_ready), 48'(1));
        void'(exp_q.pop_back());
        void'(acc_q.pop_back());
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        issue(12'h007, 12'h007, 1'b0);
        drain();
        chk("seven_x_seven", 48'(p), 48'h000031);

        // Back-to-back random operands.
        last_acc = -1;
        for (int n = 0; n < 8; n++) begin
            issue(W'($urandom), W'($urandom), 1'b1);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
